// File: rtl/chain_readout_ctrl_pkg.sv
// Shared definitions for the daisy-chain readout controller: FSM encoding,
// frame period table and default ADC width.
package chain_readout_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_TRIG = 4'b0010,
        ST_CAPT = 4'b0100,
        ST_WAIT = 4'b1000
    } state_t;

    localparam int BITS_ADC_DEF = 12;
    localparam int CH_IDX_W     = 5;

    localparam int PERIOD_MUX0 = 1024;
    localparam int PERIOD_MUX1 = 512;
    localparam int PERIOD_MUX2 = 256;
    localparam int PERIOD_MUX3 = 128;
    localparam int PERIOD_MAX  = PERIOD_MUX0;

    function automatic int unsigned period_of(input logic [1:0] mux);
        case (mux)
            2'b00:   return PERIOD_MUX0;
            2'b01:   return PERIOD_MUX1;
            2'b10:   return PERIOD_MUX2;
            default: return PERIOD_MUX3;
        endcase
    endfunction

endpackage

// File: rtl/chain_fifo.sv
// Single-clock FIFO with combinational head read. A write to a full FIFO is
// dropped unless a pop happens in the same cycle.
module chain_fifo #(
    parameter int WIDTH = 17,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
        end
    end

endmodule

// File: rtl/chain_readout_ctrl.sv
// Frame controller for the ADC daisy chain: strobes adc_ready, captures the
// returned words tagged with their channel index and buffers them for SPI.
module chain_readout_ctrl
    import chain_readout_ctrl_pkg::*;
#(
    parameter int N_BLOCK  = 8,
    parameter int BITS_ADC = BITS_ADC_DEF,
    parameter int FIFO_AW  = 4,
    parameter int TRIG_LEN = 4,
    parameter int TMO      = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            samp_rate_mux,
    output logic                  adc_ready,
    input  logic [BITS_ADC:0]     chain_in,
    input  logic                  rd_en,
    output logic [BITS_ADC+4:0]   rd_data,
    output logic                  rd_empty,
    output logic                  ovf,
    output logic                  frame_err,
    input  logic                  clr_flags
);
    localparam int WORDS = 4 * N_BLOCK;
    localparam int WCW   = ($clog2(WORDS + 1) > CH_IDX_W) ? $clog2(WORDS + 1) : CH_IDX_W;
    localparam int TCW   = $clog2(TRIG_LEN + 1);
    localparam int OCW   = $clog2(TMO + 1);
    localparam int PCW   = $clog2(PERIOD_MAX + TRIG_LEN + TMO + 2);

    state_t           state;
    logic [TCW-1:0]   trig_cnt;
    logic [OCW-1:0]   tmo_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [PCW-1:0]   per_cnt;
    logic [PCW-1:0]   period_q;

    logic             accept;
    logic             capt_full;
    logic             capt_tmo;
    logic             err_set;
    logic             ovf_set;
    logic             fifo_full;
    logic [BITS_ADC+4:0] wr_data;

    assign accept    = (state == ST_CAPT) && !chain_in[BITS_ADC];
    assign capt_full = accept && (word_cnt == WCW'(WORDS - 1));
    assign capt_tmo  = (state == ST_CAPT) && (tmo_cnt == OCW'(TMO - 1));
    assign err_set   = capt_tmo && !capt_full;
    assign ovf_set   = accept && fifo_full && !rd_en;
    assign wr_data   = {word_cnt[CH_IDX_W-1:0], chain_in[BITS_ADC-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            adc_ready <= 1'b0;
            trig_cnt  <= '0;
            tmo_cnt   <= '0;
            word_cnt  <= '0;
            per_cnt   <= '0;
            period_q  <= '0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state != ST_IDLE) begin
                per_cnt <= per_cnt + PCW'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_TRIG;
                        adc_ready <= 1'b1;
                        trig_cnt  <= '0;
                        per_cnt   <= '0;
                        period_q  <= PCW'(period_of(samp_rate_mux));
                    end
                end
                ST_TRIG: begin
                    if (trig_cnt == TCW'(TRIG_LEN - 1)) begin
                        state     <= ST_CAPT;
                        adc_ready <= 1'b0;
                        word_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + TCW'(1);
                    end
                end
                ST_CAPT: begin
                    if (accept) begin
                        word_cnt <= word_cnt + WCW'(1);
                    end
                    if (capt_full || capt_tmo) begin
                        state <= ST_WAIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + OCW'(1);
                    end
                end
                ST_WAIT: begin
                    // >= rather than == so a timed-out frame longer than the period still ends.
                    if (per_cnt >= period_q - PCW'(1)) begin
                        if (enable) begin
                            state     <= ST_TRIG;
                            adc_ready <= 1'b1;
                            trig_cnt  <= '0;
                            per_cnt   <= '0;
                            period_q  <= PCW'(period_of(samp_rate_mux));
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    adc_ready <= 1'b0;
                end
            endcase

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    chain_fifo #(
        .WIDTH (BITS_ADC + 5),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (rd_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_chain_readout_ctrl.sv
// Directed bench for chain_readout_ctrl: a chain model answers each frame,
// a popper drains and checks the FIFO, and sequences cover the corner cases.
module tb_chain_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  samp_rate_mux;
    logic        adc_ready;
    logic [12:0] chain_in;
    logic        rd_en;
    logic [16:0] rd_data;
    logic        rd_empty;
    logic        ovf;
    logic        frame_err;
    logic        clr_flags;

    always #5 clk = ~clk;

    chain_readout_ctrl #(
        .N_BLOCK  (8),
        .BITS_ADC (12),
        .FIFO_AW  (4),
        .TRIG_LEN (4),
        .TMO      (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .samp_rate_mux (samp_rate_mux),
        .adc_ready     (adc_ready),
        .chain_in      (chain_in),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .ovf           (ovf),
        .frame_err     (frame_err),
        .clr_flags     (clr_flags)
    );

    typedef struct {
        logic [1:0] mux;
        int         period;
        int         hi_len;
    } vec_t;

    int         n_err     = 0;
    int         n_chk     = 0;
    int         cyc       = 0;
    logic       ar_last   = 1'b0;
    int         model_n   = 32;
    int         sent_cnt  = 0;
    int         model_c   = 0;
    bit         model_act = 1'b0;
    bit         pop_on    = 1'b0;
    logic [4:0] exp_idx   = '0;
    int         pop_count = 0;

    function automatic logic [11:0] sample_of(input logic [4:0] k);
        logic [11:0] s;
        s = 12'(k) * 12'd173 + 12'd29;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Chain returns model_n words after adc_ready falls, skipping every 4th cycle.
    task automatic model_step();
        if (ar_last && !adc_ready) begin
            model_act = 1'b1;
            sent_cnt  = 0;
            model_c   = 0;
        end
        if (model_act && sent_cnt < model_n) begin
            if (model_c % 4 == 3) begin
                chain_in = {1'b1, 12'hABC};
            end else begin
                chain_in = {1'b0, sample_of(5'(sent_cnt))};
                sent_cnt++;
            end
            model_c++;
        end else begin
            model_act = 1'b0;
            chain_in  = {1'b1, 12'h5A5};
        end
    endtask

    task automatic pop_step();
        if (pop_on && !rd_empty) begin
            check("pop_word", 32'(rd_data), 32'({exp_idx, sample_of(exp_idx)}));
            exp_idx++;
            pop_count++;
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    endtask

    task automatic tick();
        ar_last = adc_ready;
        @(negedge clk);
        cyc++;
        model_step();
        pop_step();
    endtask

    task automatic wait_rise(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (adc_ready && !ar_last) begin
                ok = 1'b1;
                break;
            end
        end
        check("adc_ready_rise_seen", 32'(ok), 32'd1);
    endtask

    task automatic measure(output int hi, output int per);
        int t0;
        t0 = cyc;
        hi = 0;
        while (adc_ready && hi < 50) begin
            hi++;
            tick();
        end
        wait_rise(2000);
        per = cyc - t0;
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    initial begin
        vec_t tbl [3];
        int   hi;
        int   per;
        int   t0;
        int   pc0;
        int   rises;

        tbl[0] = '{mux: 2'b11, period: 128, hi_len: 4};
        tbl[1] = '{mux: 2'b10, period: 256, hi_len: 4};
        tbl[2] = '{mux: 2'b01, period: 512, hi_len: 4};

        rst_n         = 1'b0;
        enable        = 1'b0;
        samp_rate_mux = 2'b11;
        clr_flags     = 1'b0;
        rd_en         = 1'b0;
        chain_in      = {1'b1, 12'h000};

        // Reset state and idle without enable
        repeat (3) tick();
        check("rst_adc_ready", 32'(adc_ready), 32'd0);
        check("rst_rd_empty", 32'(rd_empty), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_without_enable", 32'(adc_ready), 32'd0);

        // Period table with continuous popping of full 32-word frames
        enable = 1'b1;
        pop_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp_rate_mux = tbl[i].mux;
            wait_rise(2000);
            measure(hi, per);
            check("adc_ready_high_len", 32'(hi), 32'(tbl[i].hi_len));
            check("frame_period", 32'(per), 32'(tbl[i].period));
        end
        check("full_frames_no_err", 32'(frame_err), 32'd0);
        check("full_frames_no_ovf", 32'(ovf), 32'd0);

        // Rate change mid-frame applies from the next frame only
        samp_rate_mux = 2'b11;
        wait_rise(2000);
        t0 = cyc;
        repeat (20) tick();
        samp_rate_mux = 2'b00;
        wait_rise(2000);
        check("period_after_midframe_change", 32'(cyc - t0), 32'd128);
        t0 = cyc;
        wait_rise(2000);
        check("period_next_frame_1024", 32'(cyc - t0), 32'd1024);

        // Short frame: 30 words, timeout flags frame_err at CAPT entry + 255
        samp_rate_mux = 2'b11;
        wait_rise(2000);
        model_n = 30;
        for (int i = 0; i < 10 && adc_ready; i++) tick();
        t0 = cyc;
        check("err_clear_at_capt_entry", 32'(frame_err), 32'd0);
        for (int i = 0; i < 400 && !frame_err; i++) tick();
        check("frame_err_set", 32'(frame_err), 32'd1);
        check("frame_err_latency", 32'(cyc - t0), 32'd255);
        check("short_frame_pops", 32'(exp_idx), 32'd30);
        exp_idx = '0;
        model_n = 32;
        wait_rise(2000);
        pc0 = pop_count;
        repeat (60) tick();
        check("restart_frame_pops", 32'(pop_count - pc0), 32'd32);
        check("frame_err_sticky", 32'(frame_err), 32'd1);
        clr_pulse();
        check("frame_err_cleared", 32'(frame_err), 32'd0);

        // Overflow: single frame without pops keeps first 16 words
        wait_rise(2000);
        enable = 1'b0;
        pop_on = 1'b0;
        check("ovf_test_start_empty", 32'(rd_empty), 32'd1);
        exp_idx = '0;
        rises   = 0;
        repeat (200) begin
            tick();
            if (adc_ready && !ar_last) rises++;
        end
        check("no_frame_when_disabled", 32'(rises), 32'd0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_fifo_nonempty", 32'(rd_empty), 32'd0);
        pc0    = pop_count;
        pop_on = 1'b1;
        repeat (30) tick();
        check("ovf_retained_words", 32'(pop_count - pc0), 32'd16);
        check("ovf_drained_empty", 32'(rd_empty), 32'd1);
        check("ovf_still_sticky", 32'(ovf), 32'd1);
        clr_pulse();
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Pop while full and writing: nothing lost, no overflow
        pop_on  = 1'b0;
        exp_idx = '0;
        enable  = 1'b1;
        wait_rise(2000);
        enable = 1'b0;
        for (int i = 0; i < 100 && sent_cnt != 16; i++) tick();
        check("fill_to_16", 32'(sent_cnt), 32'd16);
        pc0    = pop_count;
        pop_on = 1'b1;
        repeat (100) tick();
        check("full_pop_all_words", 32'(pop_count - pc0), 32'd32);
        check("full_pop_no_ovf", 32'(ovf), 32'd0);
        check("full_pop_empty", 32'(rd_empty), 32'd1);

        // Reset during capture after 10 words
        pop_on = 1'b0;
        enable = 1'b1;
        wait_rise(2000);
        for (int i = 0; i < 60 && sent_cnt != 10; i++) tick();
        tick();
        check("pre_reset_nonempty", 32'(rd_empty), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_empty", 32'(rd_empty), 32'd1);
        check("async_rst_adc_ready", 32'(adc_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        check("release_adc_ready", 32'(adc_ready), 32'd0);
        pop_on  = 1'b1;
        exp_idx = '0;
        pc0     = pop_count;
        tick();
        check("retrig_after_release", 32'(adc_ready), 32'd1);
        repeat (100) tick();
        check("post_reset_frame_pops", 32'(pop_count - pc0), 32'd32);
        check("post_reset_no_err", 32'(frame_err), 32'd0);
        enable = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
